// File: rtl/path_walker_pkg.sv
// Shared constants, FSM state type and node-extract helper for path_walker.
//   NODE_W     bits per node ID
//   MAX_NODES  node slots in a packed path
//   PATH_W     width of a packed path
//   LEN_W      width of a path length / node index
//   TO_W       width of the inter-node timeout counter
package path_walker_pkg;

  localparam int unsigned NODE_W    = 5;
  localparam int unsigned MAX_NODES = 14;
  localparam int unsigned PATH_W    = NODE_W * MAX_NODES;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned TO_W      = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  // Paths are right-aligned: node 0 sits in the most significant occupied slot.
  // Caller guarantees 1 <= len and k <= len-1.
  function automatic logic [NODE_W-1:0] get_node(input logic [PATH_W-1:0] path,
                                                  input logic [LEN_W-1:0]  len,
                                                  input logic [LEN_W-1:0]  k);
    logic [PATH_W-1:0] shifted;
    shifted = path >> (NODE_W * (int'(len) - int'(k) - 1));
    return shifted[NODE_W-1:0];
  endfunction

endpackage

// File: rtl/path_walker_slot_buf.sv
// path_slot_buf: single-entry shadow register holding the next path.
//   clk, rst_n  clock, synchronous active-low reset
//   path_in     packed path from the CPU
//   path_len    valid node count (1..MAX_NODES accepted)
//   path_valid  strobe qualifying path_in/path_len
//   take        walker moves the slot into its active path this cycle
//   slot_path   held path
//   slot_len    held length
//   slot_valid  slot holds a path
//   overrun     1-cycle pulse: a strobe was dropped (slot full or bad length)
module path_slot_buf
  import path_walker_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PATH_W-1:0] path_in,
  input  logic [LEN_W-1:0]  path_len,
  input  logic              path_valid,
  input  logic              take,
  output logic [PATH_W-1:0] slot_path,
  output logic [LEN_W-1:0]  slot_len,
  output logic              slot_valid,
  output logic              overrun
);

  logic len_ok;
  logic capture;

  assign len_ok  = (path_len != '0) && (path_len <= LEN_W'(MAX_NODES));
  // A slot being taken this cycle counts as free, so it can refill immediately.
  assign capture = path_valid && len_ok && (!slot_valid || take);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_path  <= '0;
      slot_len   <= '0;
      slot_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= path_valid && !capture;
      if (capture) begin
        slot_path  <= path_in;
        slot_len   <= path_len;
        slot_valid <= 1'b1;
      end else if (take) begin
        slot_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/path_walker.sv
// path_walker: steps a packed node path, one node per node_reached pulse,
// with a one-deep shadow slot so the CPU can queue the next path.
// Optional inter-node timeout enabled by defining PATH_WALKER_TIMEOUT_EN.
//   clk, rst_n    clock, synchronous active-low reset
//   path_in       packed path, node k at [NODE_W*(len-1-k) +: NODE_W]
//   path_len      valid node count
//   path_valid    strobe for path_in/path_len
//   node_reached  bot arrived at next_node
//   abort         drop the active path
//   cur_node      node the bot is at / leaving
//   next_node     node the bot is heading to
//   node_idx      index of cur_node in the active path
//   busy          walking a path
//   done          1-cycle pulse: final node reached
//   new_path      1-cycle pulse: slot moves to active, CPU may send another path
//   overrun       1-cycle pulse: path strobe dropped
//   timeout_err   sticky until next load; 0 without PATH_WALKER_TIMEOUT_EN
module path_walker
  import path_walker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PATH_W-1:0] path_in,
  input  logic [LEN_W-1:0]  path_len,
  input  logic              path_valid,
  input  logic              node_reached,
  input  logic              abort,
  output logic [NODE_W-1:0] cur_node,
  output logic [NODE_W-1:0] next_node,
  output logic [LEN_W-1:0]  node_idx,
  output logic              busy,
  output logic              done,
  output logic              new_path,
  output logic              overrun,
  output logic              timeout_err
);

  state_t            state, next_state;
  logic [PATH_W-1:0] act_path;
  logic [LEN_W-1:0]  act_len;
  logic [PATH_W-1:0] slot_path;
  logic [LEN_W-1:0]  slot_len;
  logic              slot_valid;
  logic              load;
  logic              step;
  logic [LEN_W:0]    idx_p2;
  logic [LEN_W:0]    last_k;
  logic [LEN_W-1:0]  step_k;
  logic [LEN_W-1:0]  load_k;
  logic              at_last;

  path_slot_buf u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .path_in    (path_in),
    .path_len   (path_len),
    .path_valid (path_valid),
    .take       (load),
    .slot_path  (slot_path),
    .slot_len   (slot_len),
    .slot_valid (slot_valid),
    .overrun    (overrun)
  );

  // Lookahead node after a step is node[idx+2], clamped to the last node.
  assign idx_p2  = {1'b0, node_idx} + (LEN_W+1)'(2);
  assign last_k  = {1'b0, act_len} - (LEN_W+1)'(1);
  assign step_k  = (idx_p2 > last_k) ? last_k[LEN_W-1:0] : idx_p2[LEN_W-1:0];
  assign load_k  = (slot_len == LEN_W'(1)) ? '0 : LEN_W'(1);
  assign at_last = (node_idx + LEN_W'(1)) == (act_len - LEN_W'(1));

`ifdef PATH_WALKER_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_fire;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
`ifdef PATH_WALKER_TIMEOUT_EN
    to_fire    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (slot_valid) begin
          load       = 1'b1;
          next_state = WALK;
        end
      end
      WALK: begin
        if (abort) begin
          next_state = IDLE;
        end else if (act_len == LEN_W'(1)) begin
          next_state = DONE;
        end else if (node_reached) begin
          step = 1'b1;
          if (at_last) next_state = DONE;
        end
`ifdef PATH_WALKER_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          to_fire    = 1'b1;
          next_state = IDLE;
        end
`endif
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_path  <= '0;
      act_len   <= '0;
      node_idx  <= '0;
      cur_node  <= '0;
      next_node <= '0;
    end else if (load) begin
      act_path  <= slot_path;
      act_len   <= slot_len;
      node_idx  <= '0;
      cur_node  <= get_node(slot_path, slot_len, '0);
      next_node <= get_node(slot_path, slot_len, load_k);
    end else if (step) begin
      node_idx  <= node_idx + LEN_W'(1);
      cur_node  <= next_node;
      next_node <= get_node(act_path, act_len, step_k);
    end
  end

`ifdef PATH_WALKER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WALK || step) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TO_W'(1);
      if (load)         timeout_err <= 1'b0;
      else if (to_fire) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  assign busy     = (state == WALK);
  assign done     = (state == DONE);
  assign new_path = load;

endmodule

// File: tb/tb_path_walker.sv
module tb_path_walker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [69:0] path_in;
  logic [3:0]  path_len;
  logic        path_valid;
  logic        node_reached;
  logic        abort;
  logic [4:0]  cur_node;
  logic [4:0]  next_node;
  logic [3:0]  node_idx;
  logic        busy;
  logic        done;
  logic        new_path;
  logic        overrun;
  logic        timeout_err;

  always #5 clk = ~clk;

  path_walker #(.TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .path_in      (path_in),
    .path_len     (path_len),
    .path_valid   (path_valid),
    .node_reached (node_reached),
    .abort        (abort),
    .cur_node     (cur_node),
    .next_node    (next_node),
    .node_idx     (node_idx),
    .busy         (busy),
    .done         (done),
    .new_path     (new_path),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [69:0] act_p, slot_p;
  int unsigned act_len, slot_len, act_idx;
  bit          act_on, slot_on;
  int unsigned exp_done, exp_ovr, exp_np;
  logic [15:0] sb_q[$];

  function automatic logic [4:0] tb_node(input logic [69:0] p, input int unsigned len,
                                         input int unsigned k);
    logic [4:0]  r;
    int unsigned base;
    base = 5 * (len - 1 - k);
    for (int unsigned b = 0; b < 5; b++) r[b] = p[base + b];
    return r;
  endfunction

  function automatic logic [69:0] mk_path(input int unsigned seed, input int unsigned len);
    logic [69:0] p;
    logic [4:0]  n;
    p = '0;
    for (int unsigned k = 0; k < len; k++) begin
      n = 5'((seed + 7 * k) % 32);
      for (int unsigned b = 0; b < 5; b++) p[5 * (len - 1 - k) + b] = n[b];
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load();
    logic [4:0] n0, n1;
    n0 = tb_node(act_p, act_len, 0);
    n1 = (act_len > 1) ? tb_node(act_p, act_len, 1) : n0;
    sb_q.push_back({n0, n1, 4'd0, 1'b1, 1'b0});
    exp_np++;
    act_idx = 0;
    act_on  = 1;
    if (act_len == 1) begin
      exp_done++;
      act_on = 0;
    end
  endtask

  task automatic model_pull();
    while (!act_on && slot_on) begin
      act_p   = slot_p;
      act_len = slot_len;
      slot_on = 0;
      push_load();
    end
  endtask

  task automatic send_path(input logic [69:0] p, input int unsigned len);
    path_in    = p;
    path_len   = 4'(len);
    path_valid = 1'b1;
    if (len < 1 || len > 14 || slot_on) exp_ovr++;
    else begin
      slot_p   = p;
      slot_len = len;
      slot_on  = 1;
      model_pull();
    end
    tick();
    path_valid = 1'b0;
  endtask

  task automatic reach();
    logic [4:0]  c, n;
    int unsigned nk;
    bit          fin;
    node_reached = 1'b1;
    if (act_on && act_len > 1) begin
      act_idx++;
      c   = tb_node(act_p, act_len, act_idx);
      nk  = (act_idx + 1 > act_len - 1) ? act_len - 1 : act_idx + 1;
      n   = tb_node(act_p, act_len, nk);
      fin = (act_idx == act_len - 1);
      sb_q.push_back({c, n, 4'(act_idx), !fin, fin});
      if (fin) begin
        exp_done++;
        act_on = 0;
        model_pull();
      end
    end
    tick();
    node_reached = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    if (act_on) begin
      act_on = 0;
      model_pull();
    end
    tick();
    abort = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  logic        prev_busy, prev_np;
  logic [3:0]  prev_idx;
  int unsigned seen_done = 0, seen_ovr = 0, seen_np = 0;
  logic [15:0] sb_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy <= 1'b0;
      prev_np   <= 1'b0;
      prev_idx  <= '0;
    end else begin
      if ((busy && !prev_busy) || ((busy || done) && node_idx != prev_idx)) begin
        if (busy && !prev_busy) check("new_path_before_load", 32'(prev_np), 32'd1);
        check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          check("node_state", 32'({cur_node, next_node, node_idx, busy, done}), 32'(sb_exp));
        end
      end
      if (done)     seen_done++;
      if (overrun)  seen_ovr++;
      if (new_path) seen_np++;
      prev_busy <= busy;
      prev_np   <= new_path;
      prev_idx  <= node_idx;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  int unsigned cyc, err_cyc, d0, o0;

  initial begin
    rst_n = 1'b0; path_in = '0; path_len = '0; path_valid = 1'b0;
    node_reached = 1'b0; abort = 1'b0;
    act_on = 0; slot_on = 0; act_len = 0; slot_len = 0; act_idx = 0;
    exp_done = 0; exp_ovr = 0; exp_np = 0;
    repeat (3) tick();
    check("reset_outputs", 32'({cur_node, next_node, node_idx, busy, done, new_path,
                                overrun, timeout_err}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 32'({busy, done, new_path, overrun}), 32'd0);

    // Path 0-1-2-3 with latency check
    send_path(70'(20'b00000_00001_00010_00011), 4);
    check("busy_latency_n1", 32'(busy), 32'd0);
    tick();
    check("busy_latency_n2", 32'(busy), 32'd1);
    d0 = seen_done;
    for (int i = 0; i < 3; i++) begin
      check("no_early_done", seen_done - d0, 32'd0);
      reach();
      tick();
    end
    tick();
    check("done_once", seen_done - d0, 32'd1);

    // Back-to-back: B sent during A's transfer cycle, C dropped while B is held
    o0 = seen_ovr;
    send_path(mk_path(3, 5), 5);
    send_path(mk_path(11, 3), 3);
    tick(); tick();
    check("b_held_no_overrun", seen_ovr - o0, 32'd0);
    send_path(mk_path(20, 2), 2);
    tick();
    check("c_overrun", seen_ovr - o0, 32'd1);
    for (int i = 0; i < 3; i++) begin reach(); tick(); end
    reach();
    check("a_done_pulse", 32'(done), 32'd1);
    tick();
    check("b_transfer", 32'({new_path, busy}), 32'b10);
    tick();
    check("b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 2; i++) begin reach(); tick(); end
    tick(); tick();

    // Illegal lengths
    o0 = seen_ovr;
    send_path(mk_path(5, 4), 0);
    send_path(mk_path(6, 4), 15);
    tick(); tick(); tick();
    check("badlen_overrun", seen_ovr - o0, 32'd2);
    check("badlen_idle", 32'(busy), 32'd0);
    check("badlen_no_load", seen_np, exp_np);

    // Abort after second step, held path then walks normally
    d0 = seen_done;
    send_path(mk_path(9, 5), 5);
    tick();
    reach(); tick();
    reach(); tick();
    send_path(mk_path(17, 3), 3);
    do_abort();
    check("abort_busy_drop", 32'(busy), 32'd0);
    tick();
    check("abort_no_done", seen_done - d0, 32'd0);
    tick();
    check("held_loads_after_abort", 32'(busy), 32'd1);
    for (int i = 0; i < 2; i++) begin reach(); tick(); end
    tick(); tick();
    check("held_walk_done", seen_done - d0, 32'd1);

    // Single-node path completes without node_reached
    d0 = seen_done;
    send_path(mk_path(30, 1), 1);
    repeat (4) tick();
    check("len1_done", seen_done - d0, 32'd1);

    // Reset mid-walk discards active and held paths
    send_path(mk_path(2, 4), 4);
    tick();
    reach(); tick();
    send_path(mk_path(13, 4), 4);
    rst_n = 1'b0;
    act_on = 0; slot_on = 0;
    tick();
    check("midreset_outputs", 32'({cur_node, next_node, node_idx, busy, done, new_path,
                                   overrun, timeout_err}), 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("midreset_slot_empty", 32'({busy, new_path}), 32'd0);

    // Inter-node timeout
    send_path(mk_path(21, 4), 4);
    tick();
    cyc = 0; err_cyc = 0;
`ifdef PATH_WALKER_TIMEOUT_EN
    while (busy && cyc < 500) begin
      cyc++;
      tick();
    end
    act_on = 0;
    check("timeout_walk_cycles", cyc, 32'd100);
    check("timeout_err_set", 32'({timeout_err, busy}), 32'b10);
    send_path(mk_path(25, 3), 3);
    tick();
    check("timeout_err_clear", 32'({timeout_err, busy}), 32'b01);
    do_abort();
`else
    while (busy && cyc < 150) begin
      cyc++;
      if (timeout_err) err_cyc++;
      tick();
    end
    check("no_timeout_busy", cyc, 32'd150);
    check("no_timeout_err", err_cyc, 32'd0);
    do_abort();
`endif
    repeat (3) tick();

    check("total_done", seen_done, exp_done);
    check("total_overrun", seen_ovr, exp_ovr);
    check("total_new_path", seen_np, exp_np);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
